pipelined_alu: RTL and testbench

- Parametrised, registered successor to the fixed-width 64-bit ripple ALU.
- Width is generic, with a 4-bit RISC-V-style ALU control code.
- Adds SUB, SLT, NOR, a multi-cycle shift-add MUL, registered flags (zero, carry, overflow, negative) and valid/ready handshakes on both sides.
- Sits between the operand-fetch stage and writeback in the RISC-V datapath; backpressure stalls issue.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_core.sv | 50 +++++
 rtl/pipelined_alu.sv | 171 +++++++++++++++++
 tb/tb_pipelined_alu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and an opcode legality helper for the pipelined ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic {
        StIdle,
        StMul
    } alu_state_e;

    function automatic logic is_legal_op(input logic [3:0] ctl);
        return (ctl == ALU_AND) || (ctl == ALU_OR)  || (ctl == ALU_ADD) ||
               (ctl == ALU_SUB) || (ctl == ALU_SLT) || (ctl == ALU_NOR) ||
               (ctl == ALU_MUL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational logic/add/sub/SLT unit. MUL is handled by the iterative datapath in the top.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             op_err
);

    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic             add_ovf;

    // Shared adder: SUB and SLT both use a + ~b + 1.
    always_comb begin
        is_sub  = (alu_ctl == ALU_SUB) || (alu_ctl == ALU_SLT);
        b_op    = is_sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
        add_ovf = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

    // Opcode decode; flags only meaningful for ADD/SUB.
    always_comb begin
        result    = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        op_err    = !is_legal_op(alu_ctl);
        case (alu_ctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD, ALU_SUB: begin
                result    = sum[WIDTH-1:0];
                carry_out = sum[WIDTH];
                overflow  = add_ovf;
            end
            // True signed compare: sign of the difference corrected by overflow.
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_alu.sv
// Registered ALU with valid/ready handshakes and an iterative shift-add multiplier.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zf,
    output logic             nf,
    output logic             op_err
);

    alu_state_e         state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               zf_q, zf_d;
    logic               nf_q, nf_d;
    logic               err_q, err_d;

    logic               out_free;
    logic               fire_in;
    logic               mul_done;
    logic               wr;

    logic [WIDTH-1:0]   core_result;
    logic               core_carry;
    logic               core_ovf;
    logic               core_err;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a         (a),
        .b         (b),
        .alu_ctl   (alu_ctl),
        .result    (core_result),
        .carry_out (core_carry),
        .overflow  (core_ovf),
        .op_err    (core_err)
    );

    // Output slot is free if empty or being drained this cycle.
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == StIdle) && out_free;
    assign fire_in  = in_valid && in_ready;
    // A finished product waits for a free output slot rather than overwrite an unread result.
    assign mul_done = (state_q == StMul) && (count_q == '0) && out_free;

    // MUL FSM and shift-add datapath next state.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        case (state_q)
            StIdle: begin
                if (fire_in && (alu_ctl == ALU_MUL)) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    count_d  = CNT_W'(WIDTH);
                    state_d  = StMul;
                end
            end
            StMul: begin
                if (count_q != '0) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q - CNT_W'(1);
                end else if (out_free) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register next state: new single-cycle result, MUL result, or drain.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        wr          = 1'b0;
        if (fire_in && (alu_ctl != ALU_MUL)) begin
            wr       = 1'b1;
            result_d = core_result;
            carry_d  = core_carry;
            ovf_d    = core_ovf;
            err_d    = core_err;
        end else if (mul_done) begin
            wr       = 1'b1;
            result_d = acc_q[WIDTH-1:0];
            carry_d  = 1'b0;
            ovf_d    = |acc_q[2*WIDTH-1:WIDTH];
            err_d    = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (wr) begin
            out_valid_d = 1'b1;
        end
        // Flags only change when a result is written, so they read 0 out of reset.
        zf_d = wr ? ~|result_d : zf_q;
        nf_d = wr ? result_d[WIDTH-1] : nf_q;
    end

    // State and output registers with synchronous reset; reset also aborts a MUL.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zf_q        <= 1'b0;
            nf_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zf_q        <= zf_d;
            nf_q        <= nf_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign zf        = zf_q;
    assign nf        = nf_q;
    assign op_err    = err_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu at WIDTH=8 against an integer reference model.
module tb_pipelined_alu;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   alu_ctl = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zf;
    logic         nf;
    logic         op_err;

    int n_pass = 0;
    int n_total = 0;

    // {out_valid, result, carry, overflow, zf, nf, op_err}
    logic [W+5:0] obs;
    assign obs = {out_valid, result, carry_out, overflow, zf, nf, op_err};

    pipelined_alu #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_ctl   (alu_ctl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zf        (zf),
        .nf        (nf),
        .op_err    (op_err)
    );

    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic; returns the full expected output vector.
    function automatic logic [W+5:0] model(input logic [3:0] c, input int ua, input int ub);
        int sa, sb, s, res;
        bit cy, ov, err;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        res = 0; cy = 0; ov = 0; err = 0;
        case (c)
            4'd0:  res = ua & ub;
            4'd1:  res = ua | ub;
            4'd12: res = 255 - (ua | ub);
            4'd2: begin
                s = ua + ub; res = s % 256; cy = (s > 255);
                ov = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            4'd6: begin
                res = (ua - ub + 256) % 256; cy = (ua >= ub);
                ov = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            4'd7:  res = (sa < sb) ? 1 : 0;
            4'd8: begin
                s = ua * ub; res = s % 256; ov = (s > 255);
            end
            default: err = 1;
        endcase
        return {1'b1, W'(res), cy, ov, (res == 0), (res > 127), err};
    endfunction

    // Present an op and return #1 after the edge that accepts it; bounded wait for in_ready.
    task automatic drive_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        in_valid = 1'b1; alu_ctl = c; a = x; b = y;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_total++;
        if ({obs, in_ready} !== {{(W+6){1'b0}}, 1'b1})
            $display("FAIL reset_state: got %b, required %b", {obs, in_ready},
                     {{(W+6){1'b0}}, 1'b1});
        else n_pass++;
    endtask

    task automatic test_add();
        logic [W+5:0] exp;
        out_ready = 1'b1;
        drive_op(4'b0010, 8'h7F, 8'h01);
        exp = model(4'b0010, 'h7F, 'h01);
        n_total++;
        if (obs !== exp) $display("FAIL add_7f_01: got %h, required %h", obs, exp);
        else n_pass++;
        n_total++;
        if (obs !== {1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0})
            $display("FAIL add_plan_const: got %h, required %h", obs,
                     {1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        else n_pass++;
    endtask

    task automatic test_sub_slt();
        logic [W+5:0] exp;
        drive_op(4'b0110, 8'h05, 8'h05);
        exp = model(4'b0110, 5, 5);
        n_total++;
        if (obs !== exp) $display("FAIL sub_equal: got %h, required %h", obs, exp);
        else n_pass++;
        drive_op(4'b0111, 8'hFF, 8'h01);
        exp = model(4'b0111, 'hFF, 1);
        n_total++;
        if (obs !== exp) $display("FAIL slt_neg: got %h, required %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_mul();
        logic [W+5:0] exp;
        int cyc;
        bit rdy_seen;
        drive_op(4'b1000, 8'h10, 8'h11);
        cyc = 0; rdy_seen = 0;
        while (!out_valid && cyc < 40) begin
            if (in_ready) rdy_seen = 1;
            @(posedge clk); #1; cyc++;
        end
        n_total++;
        if (cyc !== 9) $display("FAIL mul_latency: got %0d cycles, required 9", cyc);
        else n_pass++;
        n_total++;
        if (rdy_seen) $display("FAIL mul_in_ready: got in_ready=1 during MUL, required 0");
        else n_pass++;
        exp = model(4'b1000, 'h10, 'h11);
        n_total++;
        if (obs !== exp) $display("FAIL mul_result: got %h, required %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [W+5:0] exp [3];
        logic [W-1:0] xa [3];
        logic [W-1:0] xb [3];
        for (int i = 0; i < 3; i++) begin
            xa[i] = W'($urandom); xb[i] = W'($urandom);
            exp[i] = model(4'b0010, int'(xa[i]), int'(xb[i]));
        end
        @(posedge clk); #1;          // drain any earlier result
        out_ready = 1'b0;
        drive_op(4'b0010, xa[0], xb[0]);
        in_valid = 1'b1; a = xa[1]; b = xb[1];
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({obs, in_ready} !== {exp[0], 1'b0})
                $display("FAIL stall_hold_%0d: got %h, required %h", i, {obs, in_ready},
                         {exp[0], 1'b0});
            else n_pass++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        a = xa[2]; b = xb[2];
        n_total++;
        if (obs !== exp[1]) $display("FAIL b2b_second: got %h, required %h", obs, exp[1]);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++;
        if (obs !== exp[2]) $display("FAIL b2b_third: got %h, required %h", obs, exp[2]);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drain: got out_valid=%b, required 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        logic [W+5:0] exp;
        drive_op(4'b1000, 8'hAB, 8'hCD);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_total++;
        if ({out_valid, result, in_ready} !== {1'b0, 8'h00, 1'b1})
            $display("FAIL mul_abort: got %h, required %h", {out_valid, result, in_ready},
                     {1'b0, 8'h00, 1'b1});
        else n_pass++;
        drive_op(4'b0000, 8'hF0, 8'h3C);
        exp = model(4'b0000, 'hF0, 'h3C);
        n_total++;
        if (obs !== exp) $display("FAIL and_after_abort: got %h, required %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_illegal();
        logic [W+5:0] exp;
        drive_op(4'b0101, 8'h12, 8'h34);
        exp = model(4'b0101, 'h12, 'h34);
        n_total++;
        if (obs !== exp) $display("FAIL illegal_op: got %h, required %h", obs, exp);
        else n_pass++;
        drive_op(4'b0001, 8'h12, 8'h34);
        exp = model(4'b0001, 'h12, 'h34);
        n_total++;
        if (obs !== exp) $display("FAIL or_clears_err: got %h, required %h", obs, exp);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0]   ops [8];
        logic [3:0]   c;
        logic [W-1:0] x, y;
        logic [W+5:0] exp;
        int n;
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd6;
        ops[4] = 4'd7; ops[5] = 4'd12; ops[6] = 4'd8; ops[7] = 4'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            c = (i % 8 == 7) ? 4'($urandom) : ops[$urandom_range(0, 6)];
            x = W'($urandom); y = W'($urandom);
            exp = model(c, int'(x), int'(y));
            drive_op(c, x, y);
            n = 0;
            while (!out_valid && n < 40) begin
                @(posedge clk); #1; n++;
            end
            n_total++;
            if (obs !== exp)
                $display("FAIL random_%0d ctl=%b a=%h b=%h: got %h, required %h",
                         i, c, x, y, obs, exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
